// File: rtl/acc_dp_pkg.sv
// acc_dp_pkg -- shared encodings for the accumulator datapath.
//   alu_op_e    : ALU operation codes (1xx codes depend on ACC_DATAPATH_P_SHIFT_OPS_EN)
//   mem_state_e : memory-transaction FSM states
//   acc_sel_e   : accumulator address source codes
package acc_dp_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_AND   = 3'b001,
        ALU_NOT   = 3'b010,
        ALU_ADC   = 3'b011,
        ALU_SHL   = 3'b100,
        ALU_SHR   = 3'b101,
        ALU_PASS6 = 3'b110,
        ALU_PASS7 = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        ACC_SEL_DI    = 2'd0,
        ACC_SEL_IR_LO = 2'd1,
        ACC_SEL_IR_HI = 2'd2,
        ACC_SEL_ZERO  = 2'd3
    } acc_sel_e;

endpackage

// File: rtl/acc_dp_alu.sv
// acc_dp_alu -- purely combinational ALU for acc_datapath_p.
// Configuration macro: ACC_DATAPATH_P_SHIFT_OPS_EN
//   defined   : 100 SHL x, 101 SHR x (carry = bit shifted out), 110/111 pass x
//   undefined : every 1xx code passes x with carry 0
// Ports:
//   op    in  3       operation (alu_op_e)
//   x, y  in  DATA_W  operands (x = B side, y = A side)
//   c_in  in  1       carry flag, used by ADC only
//   res   out DATA_W  result
//   c_out, z_out, n_out out 1  carry, zero, negative flags
module acc_dp_alu
    import acc_dp_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              c_in,
    output logic [DATA_W-1:0] res,
    output logic              c_out,
    output logic              z_out,
    output logic              n_out
);

    logic [DATA_W:0] sum;

    always_comb begin
        // One adder serves ADD and ADC; the carry-in is gated to ADC only.
        sum   = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, (op == ALU_ADC) & c_in};
        res   = x;
        c_out = 1'b0;
        case (op)
            ALU_ADD, ALU_ADC: begin
                res   = sum[DATA_W-1:0];
                c_out = sum[DATA_W];
            end
            ALU_AND: res = x & y;
            ALU_NOT: res = ~x;
`ifdef ACC_DATAPATH_P_SHIFT_OPS_EN
            ALU_SHL: begin
                res   = {x[DATA_W-2:0], 1'b0};
                c_out = x[DATA_W-1];
            end
            ALU_SHR: begin
                res   = {1'b0, x[DATA_W-1:1]};
                c_out = x[0];
            end
`endif
            default: begin
                res   = x;
                c_out = 1'b0;
            end
        endcase
    end

    assign z_out = (res == '0);
    assign n_out = res[DATA_W-1];

endmodule

// File: rtl/acc_datapath_p.sv
// acc_datapath_p -- accumulator-machine datapath with a simple req/ack memory port.
// Configuration macro: ACC_DATAPATH_P_SHIFT_OPS_EN (forwarded to acc_dp_alu).
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   pc_inc/pc_ld/lr_save/lr_restore program counter and link register control
//   ir_we/tr_we/di_ld               instruction, target and DI register loads
//   acc_we/a_we/b_we/res_we/czn_ld  accumulator file, operand, result, flag loads
//   acc_sel, b_src, a_zero, b_zero, alu_op   operand routing and ALU op
//   addr_sel, mem_start, mem_wr     memory transaction launch
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack   memory port
//   mem_busy, mem_done, di_out, ir_op, czn   status
module acc_datapath_p
    import acc_dp_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 13,
    parameter int ACC_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pc_inc,
    input  logic                     pc_ld,
    input  logic                     lr_save,
    input  logic                     lr_restore,
    input  logic                     ir_we,
    input  logic                     tr_we,
    input  logic                     di_ld,
    input  logic                     acc_we,
    input  logic                     a_we,
    input  logic                     b_we,
    input  logic                     res_we,
    input  logic                     czn_ld,
    input  logic [1:0]               acc_sel,
    input  logic                     b_src,
    input  logic                     a_zero,
    input  logic                     b_zero,
    input  logic [2:0]               alu_op,
    input  logic                     addr_sel,
    input  logic                     mem_start,
    input  logic                     mem_wr,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack,
    output logic                     mem_busy,
    output logic                     mem_done,
    output logic [ADDR_W-DATA_W-1:0] di_out,
    output logic [3:0]               ir_op,
    output logic [2:0]               czn
);

    localparam int ACC_AW = $clog2(ACC_DEPTH);
    localparam int DI_W   = ADDR_W - DATA_W;

    logic [ADDR_W-1:0] pc_reg, lr_reg, tr_reg, addr_reg;
    logic [DATA_W-1:0] ir_reg, mdr_reg, a_reg, b_reg, res_reg, wdata_reg;
    logic [DI_W-1:0]   di_reg;
    logic [2:0]        flags_reg;                 // {N, Z, C}
    logic              req_reg, we_reg, done_reg;
    mem_state_e        state_reg;

    logic [DATA_W-1:0] acc_mem [ACC_DEPTH];
    logic [ACC_AW-1:0] acc_addr;
    logic [DATA_W-1:0] acc_rd;

    logic [DATA_W-1:0] alu_x, alu_y, alu_res;
    logic              alu_c, alu_z, alu_n;

    // Accumulator address source.
    always_comb begin
        acc_addr = '0;
        case (acc_sel)
            ACC_SEL_DI:    acc_addr = di_reg[DI_W-1 -: ACC_AW];
            ACC_SEL_IR_LO: acc_addr = ir_reg[ACC_AW-1:0];
            ACC_SEL_IR_HI: acc_addr = ir_reg[2*ACC_AW-1:ACC_AW];
            default:       acc_addr = '0;
        endcase
    end

    // Combinational read: a write on the same edge is seen only next cycle.
    assign acc_rd = acc_mem[acc_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ACC_DEPTH; i++) acc_mem[i] <= '0;
        end else if (acc_we) begin
            acc_mem[acc_addr] <= res_reg;
        end
    end

    assign alu_x = b_zero ? '0 : b_reg;
    assign alu_y = a_zero ? '0 : a_reg;

    acc_dp_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (alu_op),
        .x     (alu_x),
        .y     (alu_y),
        .c_in  (flags_reg[0]),
        .res   (alu_res),
        .c_out (alu_c),
        .z_out (alu_z),
        .n_out (alu_n)
    );

    // Program counter, link, instruction, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= '0;
            lr_reg    <= '0;
            tr_reg    <= '0;
            ir_reg    <= '0;
            di_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            flags_reg <= '0;
        end else begin
            if (pc_ld)           pc_reg <= tr_reg;
            else if (lr_restore) pc_reg <= lr_reg;
            else if (pc_inc)     pc_reg <= pc_reg + ADDR_W'(1);
            // Captures the PC as it was before any update on this edge.
            if (lr_save) lr_reg <= pc_reg;
            if (ir_we)   ir_reg <= mdr_reg;
            if (tr_we)   tr_reg <= {ir_reg[DI_W-1:0], mdr_reg};
            if (di_ld)   di_reg <= ir_reg[DI_W-1:0];
            if (a_we)    a_reg  <= acc_rd;
            if (b_we)    b_reg  <= b_src ? acc_rd : mdr_reg;
            if (res_we)  res_reg <= alu_res;
            if (czn_ld)  flags_reg <= {alu_n, alu_z, alu_c};
        end
    end

    // Memory transaction FSM. Outputs are registered alongside the state so
    // mem_req/mem_busy/mem_done track the state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= MEM_IDLE;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            done_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            mdr_reg   <= '0;
        end else begin
            case (state_reg)
                MEM_IDLE: begin
                    if (mem_start) begin
                        state_reg <= MEM_REQ;
                        req_reg   <= 1'b1;
                        we_reg    <= mem_wr;
                        addr_reg  <= addr_sel ? tr_reg : pc_reg;
                        wdata_reg <= res_reg;
                    end
                end
                MEM_REQ: begin
                    if (mem_ack) begin
                        state_reg <= MEM_DONE;
                        req_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        done_reg  <= 1'b1;
                        if (!we_reg) mdr_reg <= mem_rdata;
                    end
                end
                MEM_DONE: begin
                    state_reg <= MEM_IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= MEM_IDLE;
                    req_reg   <= 1'b0;
                    we_reg    <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = req_reg;
    assign mem_busy  = req_reg;
    assign mem_we    = we_reg;
    assign mem_done  = done_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign di_out    = di_reg;
    assign ir_op     = ir_reg[DATA_W-1 -: 4];
    assign czn       = flags_reg;

endmodule

// File: tb/tb_acc_datapath_p.sv
// tb_acc_datapath_p -- directed self-checking bench for acc_datapath_p
// (DATA_W=8, ADDR_W=13, ACC_DEPTH=4). Expected shift results follow
// ACC_DATAPATH_P_SHIFT_OPS_EN as seen by this compilation.
module tb_acc_datapath_p;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_inc = 0, pc_ld = 0, lr_save = 0, lr_restore = 0;
    logic        ir_we = 0, tr_we = 0, di_ld = 0, acc_we = 0;
    logic        a_we = 0, b_we = 0, res_we = 0, czn_ld = 0;
    logic [1:0]  acc_sel = 0;
    logic        b_src = 0, a_zero = 0, b_zero = 0;
    logic [2:0]  alu_op = 0;
    logic        addr_sel = 0, mem_start = 0, mem_wr = 0;
    logic        mem_req, mem_we, mem_busy, mem_done;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 0;
    logic        mem_ack = 0;
    logic [4:0]  di_out;
    logic [3:0]  ir_op;
    logic [2:0]  czn;

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] t_addr;
    logic [7:0]  t_wdata, t_val;
    logic        t_we, t_stable, t_once;
    int          t_req, t_done;

    acc_datapath_p dut (
        .clk(clk), .rst(rst),
        .pc_inc(pc_inc), .pc_ld(pc_ld), .lr_save(lr_save), .lr_restore(lr_restore),
        .ir_we(ir_we), .tr_we(tr_we), .di_ld(di_ld), .acc_we(acc_we),
        .a_we(a_we), .b_we(b_we), .res_we(res_we), .czn_ld(czn_ld),
        .acc_sel(acc_sel), .b_src(b_src), .a_zero(a_zero), .b_zero(b_zero),
        .alu_op(alu_op), .addr_sel(addr_sel), .mem_start(mem_start), .mem_wr(mem_wr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_busy(mem_busy), .mem_done(mem_done),
        .di_out(di_out), .ir_op(ir_op), .czn(czn)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one complete memory transaction; ack is given after 'waits' wait cycles.
    task automatic mem_txn(input logic sel, input logic wr, input logic [7:0] rdata,
                           input int waits, output logic [12:0] addr,
                           output logic [7:0] wdata, output logic we, output int req_cycles,
                           output int done_at, output logic done_once, output logic stable);
        mem_start = 1; addr_sel = sel; mem_wr = wr;
        step();
        mem_start = 0; addr_sel = 0; mem_wr = 0;
        addr = mem_addr; wdata = mem_wdata; we = mem_we;
        req_cycles = 0; stable = 1;
        while (mem_req && req_cycles < 40) begin
            req_cycles++;
            if (mem_addr !== addr || mem_we !== we || mem_wdata !== wdata || mem_busy !== 1'b1)
                stable = 0;
            if (req_cycles == waits + 1) begin
                mem_ack = 1; mem_rdata = rdata;
            end
            step();
            mem_ack = 0;
        end
        done_at = mem_done ? req_cycles + 1 : -1;
        step();
        done_once = (done_at > 0) && !mem_done && !mem_req;
    endtask

    task automatic load_mdr(input logic [7:0] v);
        mem_txn(0, 0, v, 0, t_addr, t_wdata, t_we, t_req, t_done, t_once, t_stable);
    endtask

    task automatic read_res(output logic [7:0] v);
        mem_txn(0, 1, 8'h3C, 0, t_addr, v, t_we, t_req, t_done, t_once, t_stable);
    endtask

    // B <= MDR, then RES <= B + 0.
    task automatic res_from_mdr();
        b_src = 0; b_we = 1; step(); b_we = 0;
        a_zero = 1; alu_op = 3'b000; res_we = 1; step(); res_we = 0; a_zero = 0;
    endtask

    // RES <= 0 + A, then expose RES on the write data bus.
    task automatic read_a(output logic [7:0] v);
        b_zero = 1; alu_op = 3'b000; res_we = 1; step(); res_we = 0; b_zero = 0;
        read_res(v);
    endtask

    task automatic alu_step(input logic [2:0] op);
        alu_op = op; res_we = 1; czn_ld = 1; step(); res_we = 0; czn_ld = 0;
    endtask

    task automatic pc_now(output logic [12:0] a);
        mem_txn(0, 0, 8'h00, 0, a, t_wdata, t_we, t_req, t_done, t_once, t_stable);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1; step(); step(); rst = 0;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_busy", mem_busy, 0);
        chk("rst_mem_done", mem_done, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_czn", czn, 0);
        chk("rst_ir_op", ir_op, 0);

        // ---------------- read with 2 wait states at PC=5 ----------------
        pc_inc = 1; repeat (5) step(); pc_inc = 0;
        mem_txn(0, 0, 8'hA7, 2, t_addr, t_wdata, t_we, t_req, t_done, t_once, t_stable);
        chk("rd_addr", t_addr, 13'h005);
        chk("rd_we", t_we, 0);
        chk("rd_req_cycles", t_req, 3);
        chk("rd_done_at", t_done, 4);
        chk("rd_done_pulse", t_once, 1);
        chk("rd_held", t_stable, 1);
        res_from_mdr();
        mem_txn(0, 1, 8'h3C, 0, t_addr, t_val, t_we, t_req, t_done, t_once, t_stable);
        chk("mdr_a7", t_val, 8'hA7);
        chk("wr_we", t_we, 1);
        chk("wr_addr", t_addr, 13'h005);
        chk("min_latency_done_at", t_done, 2);
        res_from_mdr(); read_res(t_val);
        chk("mdr_after_write", t_val, 8'hA7);

        // ---------------- ignored start / ack ----------------
        mem_ack = 1; mem_rdata = 8'h11; step(); mem_ack = 0;
        chk("idle_ack_busy", mem_busy, 0);
        chk("idle_ack_done", mem_done, 0);
        res_from_mdr(); read_res(t_val);
        chk("idle_ack_mdr", t_val, 8'hA7);
        mem_start = 1; step(); mem_start = 0;
        mem_start = 1; step(); mem_start = 0;
        chk("req_start_ignored", mem_req, 1);
        mem_ack = 1; mem_rdata = 8'h22; step(); mem_ack = 0;
        chk("ign_done", mem_done, 1);
        mem_start = 1; step(); mem_start = 0;
        chk("done_start_ignored", mem_req, 0);
        step();
        chk("no_second_txn", mem_req, 0);
        res_from_mdr(); read_res(t_val);
        chk("ign_mdr", t_val, 8'h22);

        // ---------------- ADD then ADC ----------------
        load_mdr(8'hFF); res_from_mdr();
        acc_sel = 3; acc_we = 1; step(); acc_we = 0;
        a_we = 1; step(); a_we = 0;
        load_mdr(8'h01); b_src = 0; b_we = 1; step(); b_we = 0;
        alu_step(3'b000);
        chk("add_czn", czn, 3'b011);
        read_res(t_val);
        chk("add_res", t_val, 8'h00);
        a_zero = 1; b_zero = 1; alu_step(3'b011); a_zero = 0; b_zero = 0;
        chk("adc_czn", czn, 3'b000);
        read_res(t_val);
        chk("adc_res", t_val, 8'h01);

        // ---------------- accumulator addressing ----------------
        load_mdr(8'h9E); ir_we = 1; step(); ir_we = 0;
        chk("ir_op", ir_op, 4'h9);
        di_ld = 1; step(); di_ld = 0;
        chk("di_out", di_out, 5'h1E);
        load_mdr(8'h55); res_from_mdr();
        acc_sel = 1; acc_we = 1; step(); acc_we = 0;           // acc[2] = 55
        acc_sel = 0; a_we = 1; step(); a_we = 0;                // A = acc[3]
        read_a(t_val);
        chk("acc_sel0_empty", t_val, 8'h00);
        acc_sel = 3; a_we = 1; step(); a_we = 0;                // A = acc[0]
        read_a(t_val);
        chk("acc_sel3", t_val, 8'hFF);
        load_mdr(8'h66); res_from_mdr();
        acc_sel = 2; acc_we = 1; step(); acc_we = 0;           // acc[3] = 66
        acc_sel = 0; a_we = 1; step(); a_we = 0;
        read_a(t_val);
        chk("acc_sel2_sel0", t_val, 8'h66);
        acc_sel = 1; a_we = 1; step(); a_we = 0;
        read_a(t_val);
        chk("acc_sel1", t_val, 8'h55);
        load_mdr(8'h77); res_from_mdr();
        acc_sel = 1; acc_we = 1; a_we = 1; step(); acc_we = 0; a_we = 0;
        read_a(t_val);
        chk("same_edge_old", t_val, 8'h55);
        acc_sel = 1; a_we = 1; step(); a_we = 0;
        read_a(t_val);
        chk("same_edge_new", t_val, 8'h77);

        // ---------------- NOT / AND / 1xx ----------------
        load_mdr(8'h81); b_src = 0; b_we = 1; step(); b_we = 0;   // B=81, A=77
        alu_step(3'b010);
        chk("not_czn", czn, 3'b000);
        read_res(t_val);
        chk("not_res", t_val, 8'h7E);
        alu_step(3'b001);
        read_res(t_val);
        chk("and_res", t_val, 8'h01);
        alu_step(3'b100);
        read_res(t_val);
`ifdef ACC_DATAPATH_P_SHIFT_OPS_EN
        chk("shl_czn", czn, 3'b001);
        chk("shl_res", t_val, 8'h02);
`else
        chk("op100_czn", czn, 3'b100);
        chk("op100_res", t_val, 8'h81);
`endif
        alu_step(3'b111);
        read_res(t_val);
        chk("op111_czn", czn, 3'b100);
        chk("op111_res", t_val, 8'h81);

        // ---------------- call / return / wrap ----------------
        load_mdr(8'h12); ir_we = 1; step(); ir_we = 0;
        load_mdr(8'h34); tr_we = 1; step(); tr_we = 0;
        mem_txn(1, 0, 8'h00, 0, t_addr, t_wdata, t_we, t_req, t_done, t_once, t_stable);
        chk("tr_1234", t_addr, 13'h1234);
        pc_ld = 1; step(); pc_ld = 0;
        load_mdr(8'h0F); ir_we = 1; step(); ir_we = 0;
        load_mdr(8'h00); tr_we = 1; step(); tr_we = 0;
        lr_save = 1; pc_ld = 1; step(); lr_save = 0; pc_ld = 0;
        pc_now(t_addr);
        chk("call_pc", t_addr, 13'h0F00);
        lr_restore = 1; step(); lr_restore = 0;
        pc_now(t_addr);
        chk("ret_pc", t_addr, 13'h1234);
        pc_ld = 1; lr_restore = 1; pc_inc = 1; step(); pc_ld = 0; lr_restore = 0; pc_inc = 0;
        pc_now(t_addr);
        chk("prio_ld", t_addr, 13'h0F00);
        lr_restore = 1; pc_inc = 1; step(); lr_restore = 0; pc_inc = 0;
        pc_now(t_addr);
        chk("prio_restore", t_addr, 13'h1234);
        load_mdr(8'h1F); ir_we = 1; step(); ir_we = 0;
        load_mdr(8'hFF); tr_we = 1; step(); tr_we = 0;
        pc_ld = 1; step(); pc_ld = 0;
        pc_inc = 1; step(); pc_inc = 0;
        pc_now(t_addr);
        chk("pc_wrap", t_addr, 13'h0000);

        // ---------------- reset mid-REQ ----------------
        pc_inc = 1; step(); pc_inc = 0;
        mem_start = 1; step(); mem_start = 0;
        chk("pre_rst_req", mem_req, 1);
        rst = 1; step(); rst = 0;
        chk("rst_req_dropped", mem_req, 0);
        chk("rst_busy", mem_busy, 0);
        chk("rst_done", mem_done, 0);
        chk("rst2_czn", czn, 0);
        chk("rst2_ir_op", ir_op, 0);
        chk("rst2_di", di_out, 0);
        mem_ack = 1; mem_rdata = 8'hEE; step(); mem_ack = 0;
        chk("late_ack_done", mem_done, 0);
        read_res(t_val);
        chk("rst2_res", t_val, 8'h00);
        chk("rst2_pc", t_addr, 13'h0000);
        mem_txn(1, 1, 8'h00, 0, t_addr, t_wdata, t_we, t_req, t_done, t_once, t_stable);
        chk("rst2_tr", t_addr, 13'h0000);
        read_a(t_val);
        chk("rst2_a", t_val, 8'h00);
        res_from_mdr(); read_res(t_val);
        chk("rst2_mdr", t_val, 8'h00);
        acc_sel = 3; a_we = 1; step(); a_we = 0;
        read_a(t_val);
        chk("rst2_acc0", t_val, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
